// File: rtl/rd_ptr_ctrl.sv
// Per-stream read-pointer and occupancy tracker; handshakes update state one cycle later.
// Readies come only from registered counts (plus i_wr_sid): reads stall on empty streams, writes on full ones.
module rd_ptr_ctrl #(
  parameter int nstrms    = 64,
  parameter int sid_width = $clog2(nstrms),
  parameter int nports    = 8,
  parameter int ptr_width = 4,
  parameter int cnt_width = ptr_width + 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_wr_v,
  output logic                          i_wr_r,
  input  logic [sid_width-1:0]          i_wr_sid,
  input  logic [nports*nstrms-1:0]      i_req_v,
  output logic [nports*nstrms-1:0]      i_req_r,
  output logic [nstrms*ptr_width-1:0]   o_ptrs,
  output logic [nstrms*ptr_width-1:0]   o_wr_ptrs,
  output logic [nstrms*cnt_width-1:0]   o_cnt,
  output logic [nstrms-1:0]             o_full,
  output logic [nstrms-1:0]             o_empty
);

  localparam int depth = 2 ** ptr_width;

  logic [ptr_width-1:0]      ptr_q [nstrms];
  logic [cnt_width-1:0]      cnt_q [nstrms];
  logic [cnt_width-1:0]      k     [nstrms];
  logic [nports*nstrms-1:0]  fire;
  logic                      wfire;

  if (nports > depth) begin : g_bad_cfg
    $error("rd_ptr_ctrl: nports must not exceed 2**ptr_width");
  end

  for (genvar s = 0; s < nstrms; s++) begin : g_strm
    // Port p may take stream s only while more than p entries are queued, so
    // lower ports are always ready whenever a higher one is.
    for (genvar p = 0; p < nports; p++) begin : g_port
      assign i_req_r[p*nstrms+s] = cnt_q[s] > cnt_width'(p);
    end
    assign o_ptrs[s*ptr_width +: ptr_width]    = ptr_q[s];
    assign o_wr_ptrs[s*ptr_width +: ptr_width] = ptr_q[s] + cnt_q[s][ptr_width-1:0];
    assign o_cnt[s*cnt_width +: cnt_width]     = cnt_q[s];
    assign o_full[s]                           = cnt_q[s] == cnt_width'(depth);
    assign o_empty[s]                          = cnt_q[s] == '0;
  end

  assign fire   = i_req_v & i_req_r;
  assign i_wr_r = !o_full[i_wr_sid];
  assign wfire  = i_wr_v & i_wr_r;

  always_comb begin
    for (int s = 0; s < nstrms; s++) begin
      k[s] = '0;
      for (int p = 0; p < nports; p++) begin
        k[s] = k[s] + cnt_width'(fire[p*nstrms+s]);
      end
    end
  end

  // A full read of depth entries leaves the pointer unchanged, matching mod-D wrap.
  always_ff @(posedge clk) begin
    for (int s = 0; s < nstrms; s++) begin
      if (reset) begin
        ptr_q[s] <= '0;
        cnt_q[s] <= '0;
      end else begin
        ptr_q[s] <= ptr_q[s] + k[s][ptr_width-1:0];
        cnt_q[s] <= cnt_q[s] - k[s] + cnt_width'(wfire && (i_wr_sid == sid_width'(s)));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int s = 0; s < nstrms; s++) begin
        assert (cnt_q[s] <= cnt_width'(depth));
        assert (k[s] <= cnt_q[s]);
      end
      for (int p = 0; p < nports; p++) begin
        assert ($onehot0(i_req_v[p*nstrms +: nstrms]));
      end
    end
  end

endmodule

// File: tb/tb_rd_ptr_ctrl.sv
// Directed scenarios plus randomized traffic against a running-total reference model.
module tb_rd_ptr_ctrl;
  localparam int N = 64, NP = 8, PW = 4, CW = PW + 1, SW = $clog2(N), D = 2 ** PW;

  logic clk = 1'b0, reset = 1'b0, i_wr_v = 1'b0, i_wr_r;
  logic [SW-1:0]   i_wr_sid = '0;
  logic [NP*N-1:0] i_req_v = '0, i_req_r;
  logic [N*PW-1:0] o_ptrs, o_wr_ptrs;
  logic [N*CW-1:0] o_cnt;
  logic [N-1:0]    o_full, o_empty;

  int vectors = 0, miscompares = 0;
  // Model: each stream is just total entries ever written and ever read.
  int wr_tot[N], rd_tot[N];

  rd_ptr_ctrl #(.nstrms(N), .nports(NP), .ptr_width(PW)) dut (
    .clk(clk), .reset(reset), .i_wr_v(i_wr_v), .i_wr_r(i_wr_r), .i_wr_sid(i_wr_sid),
    .i_req_v(i_req_v), .i_req_r(i_req_r), .o_ptrs(o_ptrs), .o_wr_ptrs(o_wr_ptrs),
    .o_cnt(o_cnt), .o_full(o_full), .o_empty(o_empty)
  );

  always #5 clk = ~clk;

  function automatic int m_cnt(int s);
    return wr_tot[s] - rd_tot[s];
  endfunction

  function automatic logic [PW-1:0] ptr_of(int s);  return o_ptrs[s*PW +: PW];    endfunction
  function automatic logic [PW-1:0] wptr_of(int s); return o_wr_ptrs[s*PW +: PW]; endfunction
  function automatic logic [CW-1:0] cnt_of(int s);  return o_cnt[s*CW +: CW];     endfunction

  function automatic logic [NP*N-1:0] rq(int s, int nlo);
    logic [NP*N-1:0] v = '0;
    for (int p = 0; p < nlo; p++) v[p*N+s] = 1'b1;
    return v;
  endfunction

  function automatic logic [NP*N-1:0] exp_req_r();
    logic [NP*N-1:0] v = '0;
    for (int p = 0; p < NP; p++)
      for (int s = 0; s < N; s++) v[p*N+s] = (p < m_cnt(s));
    return v;
  endfunction

  function automatic logic [N*PW-1:0] exp_ptrs();
    logic [N*PW-1:0] v;
    for (int s = 0; s < N; s++) v[s*PW +: PW] = PW'(rd_tot[s] % D);
    return v;
  endfunction

  function automatic logic [N*PW-1:0] exp_wptrs();
    logic [N*PW-1:0] v;
    for (int s = 0; s < N; s++) v[s*PW +: PW] = PW'(wr_tot[s] % D);
    return v;
  endfunction

  function automatic logic [N*CW-1:0] exp_cnt();
    logic [N*CW-1:0] v;
    for (int s = 0; s < N; s++) v[s*CW +: CW] = CW'(m_cnt(s));
    return v;
  endfunction

  function automatic logic [N-1:0] exp_full();
    logic [N-1:0] v;
    for (int s = 0; s < N; s++) v[s] = (m_cnt(s) == D);
    return v;
  endfunction

  function automatic logic [N-1:0] exp_empty();
    logic [N-1:0] v;
    for (int s = 0; s < N; s++) v[s] = (m_cnt(s) == 0);
    return v;
  endfunction

  // Advance the model with the currently driven inputs, then clock the DUT.
  task automatic tick();
    int c[N];
    if (reset) begin
      for (int s = 0; s < N; s++) begin wr_tot[s] = 0; rd_tot[s] = 0; end
    end else begin
      for (int s = 0; s < N; s++) c[s] = m_cnt(s);
      for (int p = 0; p < NP; p++)
        for (int s = 0; s < N; s++)
          if (i_req_v[p*N+s] && p < c[s]) rd_tot[s]++;
      if (i_wr_v && c[i_wr_sid] < D) wr_tot[i_wr_sid]++;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; i_wr_v = 1'b0; i_req_v = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic wr(int s, int n);
    i_wr_v = 1'b1; i_wr_sid = SW'(s);
    for (int i = 0; i < n; i++) tick();
    i_wr_v = 1'b0;
  endtask

  task automatic rd(int s, int nlo);
    i_req_v = rq(s, nlo);
    tick();
    i_req_v = '0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    vectors++; if (o_empty !== {N{1'b1}}) begin miscompares++; $display("FAIL rst_empty got %h exp all ones", o_empty); end
    vectors++; if (o_full !== '0) begin miscompares++; $display("FAIL rst_full got %h exp 0", o_full); end
    vectors++; if (i_req_r !== '0) begin miscompares++; $display("FAIL rst_req_r got %h exp 0", i_req_r); end
    vectors++; if (i_wr_r !== 1'b1) begin miscompares++; $display("FAIL rst_wr_r got %b exp 1", i_wr_r); end
    vectors++; if (o_ptrs !== '0 || o_cnt !== '0) begin miscompares++; $display("FAIL rst_state ptrs %h cnt %h exp 0", o_ptrs, o_cnt); end
  endtask

  task automatic test_write_fill();
    do_reset();
    i_wr_v = 1'b1; i_wr_sid = SW'(5);
    for (int n = 1; n <= 3; n++) begin
      tick();
      vectors++; if (cnt_of(5) !== CW'(n)) begin miscompares++; $display("FAIL fill_cnt5 got %0d exp %0d", cnt_of(5), n); end
      vectors++; if (wptr_of(5) !== PW'(n)) begin miscompares++; $display("FAIL fill_wptr5 got %0d exp %0d", wptr_of(5), n); end
      vectors++; if (ptr_of(5) !== '0) begin miscompares++; $display("FAIL fill_ptr5 got %0d exp 0", ptr_of(5)); end
    end
    i_wr_v = 1'b0;
    #1;
    for (int p = 0; p < NP; p++) begin
      vectors++; if (i_req_r[p*N+5] !== (p < 3)) begin miscompares++; $display("FAIL fill_ready port %0d got %b exp %b", p, i_req_r[p*N+5], p < 3); end
    end
  endtask

  task automatic test_multi_read();
    i_req_v = rq(5, 4);
    #1;
    vectors++; if ((i_req_v & i_req_r) !== rq(5, 3)) begin miscompares++; $display("FAIL multi_fires got %h exp %h", i_req_v & i_req_r, rq(5, 3)); end
    tick();
    vectors++; if (ptr_of(5) !== PW'(3)) begin miscompares++; $display("FAIL multi_ptr5 got %0d exp 3", ptr_of(5)); end
    vectors++; if (cnt_of(5) !== '0) begin miscompares++; $display("FAIL multi_cnt5 got %0d exp 0", cnt_of(5)); end
    vectors++; if (i_req_r[3*N+5] !== 1'b0) begin miscompares++; $display("FAIL multi_port3_stall got %b exp 0", i_req_r[3*N+5]); end
    i_req_v = '0;
  endtask

  task automatic test_wrap();
    do_reset();
    wr(2, 14);
    rd(2, 8);
    rd(2, 6);
    wr(2, 4);
    vectors++; if (ptr_of(2) !== PW'(14) || cnt_of(2) !== CW'(4)) begin miscompares++; $display("FAIL wrap_setup ptr %0d cnt %0d exp 14 4", ptr_of(2), cnt_of(2)); end
    vectors++; if (wptr_of(2) !== PW'(2)) begin miscompares++; $display("FAIL wrap_wptr2 got %0d exp 2", wptr_of(2)); end
    rd(2, 4);
    vectors++; if (ptr_of(2) !== PW'(2)) begin miscompares++; $display("FAIL wrap_ptr2 got %0d exp 2", ptr_of(2)); end
    vectors++; if (cnt_of(2) !== '0) begin miscompares++; $display("FAIL wrap_cnt2 got %0d exp 0", cnt_of(2)); end
  endtask

  task automatic test_full();
    do_reset();
    wr(0, 16);
    vectors++; if (o_full[0] !== 1'b1 || cnt_of(0) !== CW'(16)) begin miscompares++; $display("FAIL full_set full %b cnt %0d exp 1 16", o_full[0], cnt_of(0)); end
    i_wr_v = 1'b1; i_wr_sid = '0; #1;
    vectors++; if (i_wr_r !== 1'b0) begin miscompares++; $display("FAIL full_wr_r0 got %b exp 0", i_wr_r); end
    i_wr_sid = SW'(1); #1;
    vectors++; if (i_wr_r !== 1'b1) begin miscompares++; $display("FAIL full_wr_r1 got %b exp 1", i_wr_r); end
    tick();
    vectors++; if (cnt_of(1) !== CW'(1)) begin miscompares++; $display("FAIL full_cnt1 got %0d exp 1", cnt_of(1)); end
    i_wr_sid = '0; i_req_v = rq(0, 1); #1;
    vectors++; if (i_wr_r !== 1'b0) begin miscompares++; $display("FAIL full_retry_refused got %b exp 0", i_wr_r); end
    tick();
    vectors++; if (cnt_of(0) !== CW'(15) || ptr_of(0) !== PW'(1)) begin miscompares++; $display("FAIL full_after_read cnt %0d ptr %0d exp 15 1", cnt_of(0), ptr_of(0)); end
    i_req_v = '0; #1;
    vectors++; if (i_wr_r !== 1'b1) begin miscompares++; $display("FAIL full_retry_ready got %b exp 1", i_wr_r); end
    tick();
    i_wr_v = 1'b0;
    vectors++; if (cnt_of(0) !== CW'(16)) begin miscompares++; $display("FAIL full_refill got %0d exp 16", cnt_of(0)); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    wr(7, 1);
    i_wr_v = 1'b1; i_wr_sid = SW'(7); i_req_v = rq(7, 1);
    tick();
    i_wr_v = 1'b0; i_req_v = '0;
    vectors++; if (cnt_of(7) !== CW'(1) || ptr_of(7) !== PW'(1) || wptr_of(7) !== PW'(2)) begin
      miscompares++; $display("FAIL rw_same cnt %0d ptr %0d wptr %0d exp 1 1 2", cnt_of(7), ptr_of(7), wptr_of(7)); end
    // empty-stream read alongside its first write: no bypass, request held
    i_req_v = rq(9, 1); i_wr_v = 1'b1; i_wr_sid = SW'(9); #1;
    vectors++; if (i_req_r[9] !== 1'b0) begin miscompares++; $display("FAIL nobypass_ready got %b exp 0", i_req_r[9]); end
    tick();
    i_wr_v = 1'b0;
    vectors++; if (cnt_of(9) !== CW'(1) || ptr_of(9) !== '0 || i_req_r[9] !== 1'b1) begin
      miscompares++; $display("FAIL nobypass_after cnt %0d ptr %0d rdy %b exp 1 0 1", cnt_of(9), ptr_of(9), i_req_r[9]); end
    tick();
    i_req_v = '0;
    vectors++; if (cnt_of(9) !== '0 || ptr_of(9) !== PW'(1)) begin miscompares++; $display("FAIL nobypass_read cnt %0d ptr %0d exp 0 1", cnt_of(9), ptr_of(9)); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    wr(3, 5); wr(4, 2);
    i_req_v = rq(3, 2) | rq(4, 1) << N*2; i_wr_v = 1'b1; i_wr_sid = SW'(4); reset = 1'b1;
    tick();
    reset = 1'b0; #1;
    vectors++; if (o_ptrs !== '0 || o_cnt !== '0) begin miscompares++; $display("FAIL midrst_state ptrs %h cnt %h exp 0", o_ptrs, o_cnt); end
    vectors++; if (i_req_r !== '0 || i_wr_r !== 1'b1) begin miscompares++; $display("FAIL midrst_hs req_r %h wr_r %b exp 0 1", i_req_r, i_wr_r); end
    i_req_v = '0; i_wr_sid = SW'(3);
    tick();
    i_wr_v = 1'b0;
    vectors++; if (o_cnt !== exp_cnt() || cnt_of(3) !== CW'(1)) begin miscompares++; $display("FAIL midrst_after got %h exp %h", o_cnt, exp_cnt()); end
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      reset    = ($urandom_range(0, 299) == 0);
      i_wr_v   = ($urandom_range(0, 99) < 70);
      i_wr_sid = SW'($urandom_range(0, 7));
      i_req_v  = '0;
      for (int p = 0; p < NP; p++)
        if ($urandom_range(0, 99) < 30) i_req_v[p*N + $urandom_range(0, 7)] = 1'b1;
      #1;
      vectors++; if (i_req_r !== exp_req_r()) begin miscompares++; $display("FAIL rnd_req_r cyc %0d got %h exp %h", cyc, i_req_r, exp_req_r()); end
      vectors++; if (i_wr_r !== (m_cnt(i_wr_sid) < D)) begin miscompares++; $display("FAIL rnd_wr_r cyc %0d got %b exp %b", cyc, i_wr_r, m_cnt(i_wr_sid) < D); end
      tick();
      vectors++; if (o_ptrs !== exp_ptrs()) begin miscompares++; $display("FAIL rnd_ptrs cyc %0d got %h exp %h", cyc, o_ptrs, exp_ptrs()); end
      vectors++; if (o_wr_ptrs !== exp_wptrs()) begin miscompares++; $display("FAIL rnd_wptrs cyc %0d got %h exp %h", cyc, o_wr_ptrs, exp_wptrs()); end
      vectors++; if (o_cnt !== exp_cnt()) begin miscompares++; $display("FAIL rnd_cnt cyc %0d got %h exp %h", cyc, o_cnt, exp_cnt()); end
      vectors++; if (o_full !== exp_full() || o_empty !== exp_empty()) begin
        miscompares++; $display("FAIL rnd_flags cyc %0d full %h empty %h exp %h %h", cyc, o_full, o_empty, exp_full(), exp_empty()); end
    end
    reset = 1'b0; i_wr_v = 1'b0; i_req_v = '0;
  endtask

  initial begin
    test_reset();
    test_write_fill();
    test_multi_read();
    test_wrap();
    test_full();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
